// File: rtl/led_pkg.sv
// Shared LED constants and helpers: default sizing, DUTY_MAX and the gamma curve,
// kept here so other LED blocks can reuse them.
package led_pkg;

  localparam int unsigned PWM_BITS_DEFAULT = 8;
  localparam logic [31:0] FADE_DIV_DEFAULT = 32'd105_467;
  localparam int unsigned GAMMA_MAX_BITS   = 16;

  function automatic int unsigned duty_max(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

  // (duty^2 + DUTY_MAX) >> bits: maps 0->0, 1->1, DUTY_MAX->DUTY_MAX
  function automatic logic [GAMMA_MAX_BITS-1:0] gamma(input logic [GAMMA_MAX_BITS-1:0] duty,
                                                      input int unsigned bits);
    logic [2*GAMMA_MAX_BITS-1:0] sq;
    sq = {16'd0, duty} * {16'd0, duty} + duty_max(bits);
    sq = sq >> bits;
    return sq[GAMMA_MAX_BITS-1:0];
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: saturating duty ramp, optional gamma (LED_PWM_GAMMA_EN), PWM compare flop.
module led_pwm_channel
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS   = PWM_BITS_DEFAULT,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_tick,
  input  logic                i_target,
  input  logic                i_en,
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  output logic                o_led,
  output logic                o_off_target
);

  localparam logic [PWM_BITS-1:0] DUTY_MAX = PWM_BITS'(duty_max(PWM_BITS));
  localparam logic [PWM_BITS-1:0] ONE      = PWM_BITS'(1);

  logic [PWM_BITS-1:0] r_duty;
  logic [PWM_BITS-1:0] w_eff;
  logic [PWM_BITS-1:0] w_endpoint;
  logic                r_led;

`ifdef LED_PWM_GAMMA_EN
  logic [GAMMA_MAX_BITS-1:0] w_gamma;
  assign w_gamma = gamma(GAMMA_MAX_BITS'(r_duty), PWM_BITS);
  assign w_eff   = w_gamma[PWM_BITS-1:0];
`else
  assign w_eff = r_duty;
`endif

  assign w_endpoint   = i_target ? DUTY_MAX : '0;
  assign o_off_target = (r_duty != w_endpoint);
  assign o_led        = r_led;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_duty <= '0;
      r_led  <= ACTIVE_LOW;
    end else begin
      if (i_tick) begin
        if (i_target && (r_duty != DUTY_MAX)) begin
          r_duty <= r_duty + ONE;
        end else if (!i_target && (r_duty != '0)) begin
          r_duty <= r_duty - ONE;
        end
      end
      r_led <= i_en ? ((i_pwm_cnt < w_eff) ^ ACTIVE_LOW) : ACTIVE_LOW;
    end
  end

endmodule

// File: rtl/led_pwm_fader.sv
// Per-channel LED PWM fader: shared PWM/fade counters, busy flag, CHANNELS channel instances.
// Build option: LED_PWM_GAMMA_EN selects gamma-corrected duty.
module led_pwm_fader
  import led_pkg::*;
#(
  parameter int unsigned CHANNELS   = 6,
  parameter int unsigned PWM_BITS   = PWM_BITS_DEFAULT,
  parameter logic [31:0] FADE_DIV   = FADE_DIV_DEFAULT,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [CHANNELS-1:0] i_led_target,
  input  logic                i_en,
  output logic [CHANNELS-1:0] o_led_out,
  output logic                o_fade_busy
);

  // Period is DUTY_MAX cycles so duty 0 is never on and DUTY_MAX is always on
  localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'(duty_max(PWM_BITS) - 32'd1);
  localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);

  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [31:0]         r_div_cnt;
  logic                r_fade_busy;
  logic                w_fade_tick;
  logic [CHANNELS-1:0] w_off_target;

  assign w_fade_tick = (r_div_cnt == FADE_DIV);
  assign o_fade_busy = r_fade_busy;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pwm_cnt   <= '0;
      r_div_cnt   <= '0;
      r_fade_busy <= 1'b0;
    end else begin
      r_pwm_cnt   <= (r_pwm_cnt == PWM_LAST) ? '0 : r_pwm_cnt + PWM_ONE;
      r_div_cnt   <= w_fade_tick ? '0 : r_div_cnt + 32'd1;
      r_fade_busy <= |w_off_target;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    led_pwm_channel #(
      .PWM_BITS   (PWM_BITS),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_tick       (w_fade_tick),
      .i_target     (i_led_target[g]),
      .i_en         (i_en),
      .i_pwm_cnt    (r_pwm_cnt),
      .o_led        (o_led_out[g]),
      .o_off_target (w_off_target[g])
    );
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Self-checking bench for led_pwm_fader (PWM_BITS=4, FADE_DIV=3, ACTIVE_LOW=1).
// Define LED_PWM_GAMMA_EN for both DUT and bench to check the gamma build.
module tb_led_pwm_fader;

  localparam int CH = 6;
  localparam int DM = 15;
  localparam int FD = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b1;
  logic [CH-1:0] tgt = '0;
  logic [CH-1:0] led;
  logic          busy;

  always #5 clk = ~clk;

  led_pwm_fader #(
    .CHANNELS   (CH),
    .PWM_BITS   (4),
    .FADE_DIV   (32'd3),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_led_target (tgt),
    .i_en         (en),
    .o_led_out    (led),
    .o_fade_busy  (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: t = cycles since reset release, duty per channel as plain integers
  int            m_t;
  int            m_duty [CH];
  logic [CH-1:0] m_led;
  logic          m_busy;

  function automatic int eff(input int d);
`ifdef LED_PWM_GAMMA_EN
    return (d * d + DM) / (DM + 1);
`else
    return d;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic e, input logic [CH-1:0] tg);
    int pwm;
    bit tick;
    if (r) begin
      m_t = 0;
      for (int i = 0; i < CH; i++) m_duty[i] = 0;
      m_led  = '1;
      m_busy = 1'b0;
    end else begin
      pwm    = m_t % DM;
      tick   = ((m_t % (FD + 1)) == FD);
      m_busy = 1'b0;
      for (int i = 0; i < CH; i++) begin
        m_led[i] = (e && (pwm < eff(m_duty[i]))) ? 1'b0 : 1'b1;
        if (m_duty[i] != (tg[i] ? DM : 0)) m_busy = 1'b1;
      end
      if (tick) begin
        for (int i = 0; i < CH; i++) begin
          if (tg[i] && m_duty[i] < DM) m_duty[i]++;
          else if (!tg[i] && m_duty[i] > 0) m_duty[i]--;
        end
      end
      m_t++;
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [CH-1:0] tg);
    @(negedge clk);
    rst = r;
    en  = e;
    tgt = tg;
    @(posedge clk);
    model_edge(r, e, tg);
    #1;
    check("led_model", led, m_led);
    check("busy_model", busy, m_busy);
  endtask

  typedef struct {
    logic          r;
    logic          e;
    logic [CH-1:0] tg;
    int            cyc;
    logic [CH-1:0] exp_led;
    logic          exp_busy;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int cnt;
    int cnt2;

    vecs[0] = '{r: 1'b1, e: 1'b1, tg: 6'h3F, cyc: 2,  exp_led: 6'h3F, exp_busy: 1'b0};
    vecs[1] = '{r: 1'b0, e: 1'b1, tg: 6'h3F, cyc: 1,  exp_led: 6'h3F, exp_busy: 1'b1};
    vecs[2] = '{r: 1'b0, e: 1'b1, tg: 6'h3F, cyc: 3,  exp_led: 6'h3F, exp_busy: 1'b1};
    vecs[3] = '{r: 1'b0, e: 1'b1, tg: 6'h3F, cyc: 12, exp_led: 6'h00, exp_busy: 1'b1};
    vecs[4] = '{r: 1'b0, e: 1'b0, tg: 6'h3F, cyc: 1,  exp_led: 6'h3F, exp_busy: 1'b1};
`ifdef LED_PWM_GAMMA_EN
    vecs[5] = '{r: 1'b0, e: 1'b1, tg: 6'h00, cyc: 1,  exp_led: 6'h3F, exp_busy: 1'b1};
`else
    vecs[5] = '{r: 1'b0, e: 1'b1, tg: 6'h00, cyc: 1,  exp_led: 6'h00, exp_busy: 1'b1};
`endif
    vecs[6] = '{r: 1'b1, e: 1'b1, tg: 6'h00, cyc: 1,  exp_led: 6'h3F, exp_busy: 1'b0};

    for (int v = 0; v < 7; v++) begin
      for (int k = 0; k < vecs[v].cyc; k++) step(vecs[v].r, vecs[v].e, vecs[v].tg);
      check("vec_led", led, vecs[v].exp_led);
      check("vec_busy", busy, vecs[v].exp_busy);
    end

    // Ramp up channel 0 to full, busy falls one cycle after the last step
    step(1'b1, 1'b1, 6'h01);
    for (int k = 0; k < 60; k++) step(1'b0, 1'b1, 6'h01);
    check("ramp_busy_before", busy, 1'b1);
    step(1'b0, 1'b1, 6'h01);
    check("ramp_busy_after", busy, 1'b0);
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      step(1'b0, 1'b1, 6'h01);
      if (led == 6'h3E) cnt++;
    end
    check("full_duty_on", cnt, 30);

    // Ramp to duty 5, reverse, reach 0 and hold without underflow
    step(1'b1, 1'b1, 6'h00);
    for (int k = 0; k < 20; k++) step(1'b0, 1'b1, 6'h01);
    for (int k = 0; k < 20; k++) step(1'b0, 1'b1, 6'h00);
    check("rev_busy_before", busy, 1'b1);
    step(1'b0, 1'b1, 6'h00);
    check("rev_busy_after", busy, 1'b0);
    cnt  = 0;
    cnt2 = 0;
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 1'b1, 6'h00);
      if (led[0] == 1'b0) cnt++;
      if (busy) cnt2++;
    end
    check("zero_hold_led", cnt, 0);
    check("zero_hold_busy", cnt2, 0);

    // Enable off mid-ramp forces pins inactive while duties keep stepping
    step(1'b1, 1'b1, 6'h3F);
    for (int k = 0; k < 30; k++) step(1'b0, 1'b1, 6'h3F);
    step(1'b0, 1'b0, 6'h3F);
    check("en_off_led", led, 6'h3F);
    for (int k = 0; k < 9; k++) step(1'b0, 1'b0, 6'h3F);
    check("en_off_busy", busy, 1'b1);
    for (int k = 0; k < 20; k++) step(1'b0, 1'b1, 6'h3F);

    // Randomized targets, enable and occasional reset against the model
    begin
      logic [CH-1:0] rt;
      logic          re;
      rt = 6'h15;
      re = 1'b1;
      for (int k = 0; k < 3000; k++) begin
        if ($urandom_range(0, 29) == 0) rt = CH'($urandom);
        if ($urandom_range(0, 39) == 0) re = ~re;
        step(($urandom_range(0, 799) == 0), re, rt);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
